// File: rtl/ps2_pkg.sv
// ---------------------------------------------------------------------------
// ps2_pkg
//   Definitions shared by the PS/2 host transmitter and the PS/2 receiver:
//   FSM state encoding, transfer error codes and the frame parity helper.
//   No ports (package).
// ---------------------------------------------------------------------------
package ps2_pkg;

  // Host transmitter FSM states. Kept as plain constants so the receiver
  // and older tooling can share the same encoding.
  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_INHIBIT = 3'd1;
  localparam logic [2:0] ST_START   = 3'd2;
  localparam logic [2:0] ST_DATA    = 3'd3;
  localparam logic [2:0] ST_PARITY  = 3'd4;
  localparam logic [2:0] ST_STOP    = 3'd5;

  // Error code reported alongside tx_err.
  typedef logic [1:0] ps2_err_t;

  localparam ps2_err_t ERR_NONE    = 2'b00;
  localparam ps2_err_t ERR_NACK    = 2'b01;
  localparam ps2_err_t ERR_TIMEOUT = 2'b10;

  // Parity bit appended after the eight data bits.
  // odd=1 gives the standard PS/2 odd parity (total number of ones odd).
  function automatic logic ps2_parity(input logic [7:0] data, input logic odd);
    return odd ? ~^data : ^data;
  endfunction

endpackage

// File: rtl/ps2_edge_filter.sv
// ---------------------------------------------------------------------------
// ps2_edge_filter
//   Brings an asynchronous PS/2 clock line into the clk domain, debounces it
//   and emits a one-cycle strobe on each filtered falling edge.
//   Shared between the PS/2 host transmitter and the PS/2 receiver.
//
// Ports
//   clk     in   system clock
//   rst_n   in   asynchronous active-low reset
//   line_i  in   raw pad level (asynchronous)
//   fall_o  out  one-cycle strobe: filtered level went 1 -> 0
// ---------------------------------------------------------------------------
module ps2_edge_filter #(
  parameter int FILTER_LEN = 8   // consecutive equal samples to change level (>=2)
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN) + 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          level_q;
  logic          level_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          fall_q;
  logic          fall_d;

  // The counter tracks how many consecutive synchronised samples disagree
  // with the current filtered level; any agreeing sample restarts it, so a
  // pulse shorter than FILTER_LEN cycles never reaches the output.
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    fall_d = level_q & ~level_d;
  end

  // An idle PS/2 bus is pulled high, so every stage resets to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      fall_q  <= 1'b0;
    end else begin
      sync1_q <= line_i;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      fall_q  <= fall_d;
    end
  end

  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// ---------------------------------------------------------------------------
// ps2_host_tx
//   PS/2 host-to-device transmitter. Sends one command byte to a mouse or
//   keyboard: inhibits the bus, issues the start condition, shifts out
//   eight data bits plus parity on device-generated clock edges, releases
//   the line for the stop bit and checks the device ACK. Every device clock
//   period is supervised by a timeout.
//
// Ports
//   clk          in     system clock
//   rst_n        in     asynchronous active-low reset
//   tx_req       in     send request, only honoured while idle
//   tx_data[7:0] in     byte to send, captured when tx_req is accepted
//   ps2_clk      inout  open-drain PS/2 clock (driven 0 or released)
//   ps2_data     inout  open-drain PS/2 data  (driven 0 or released)
//   tx_idle      out    high only while idle
//   tx_done      out    one-cycle pulse: byte sent and ACK seen
//   tx_err       out    one-cycle pulse: transfer aborted
//   tx_err_code  out    01 NACK, 10 TIMEOUT; holds the last code
// ---------------------------------------------------------------------------
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int INHIBIT_CYCLES = 8192,
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  parameter int ODD_PARITY     = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tx_req,
  input  logic [7:0] tx_data,
  inout  wire        ps2_clk,
  inout  wire        ps2_data,
  output logic       tx_idle,
  output logic       tx_done,
  output logic       tx_err,
  output logic [1:0] tx_err_code
);

  localparam int IW = $clog2(INHIBIT_CYCLES) + 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  localparam int BW = $clog2(8) + 1;

  localparam logic [IW-1:0] INH_LOAD = IW'(INHIBIT_CYCLES - 1);
  localparam logic [TW-1:0] TO_LAST  = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(7);

  // ------------------------------------------------------------------
  // Input conditioning
  // ------------------------------------------------------------------
  logic fall;
  logic data_s1_q;
  logic data_s2_q;

  ps2_edge_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk    (clk),
    .rst_n  (rst_n),
    .line_i (ps2_clk),
    .fall_o (fall)
  );

  // Data only needs metastability protection: it is sampled once, at a
  // filtered clock edge, long after the device has settled it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_s1_q <= 1'b1;
      data_s2_q <= 1'b1;
    end else begin
      data_s1_q <= ps2_data;
      data_s2_q <= data_s1_q;
    end
  end

  // ------------------------------------------------------------------
  // FSM and datapath
  // ------------------------------------------------------------------
  logic [2:0]    state_q,    state_d;
  logic [8:0]    shift_q,    shift_d;      // {parity, data[7:0]}, LSB out first
  logic [BW-1:0] bit_cnt_q,  bit_cnt_d;
  logic [IW-1:0] inh_cnt_q,  inh_cnt_d;    // counts down to 0
  logic [TW-1:0] to_cnt_q,   to_cnt_d;     // cycles since last device edge
  logic          done_q,     done_d;
  logic          err_q,      err_d;
  ps2_err_t      err_code_q, err_code_d;

  logic busy;
  assign busy = (state_q == ST_START)  || (state_q == ST_DATA) ||
                (state_q == ST_PARITY) || (state_q == ST_STOP);

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    bit_cnt_d  = bit_cnt_q;
    inh_cnt_d  = inh_cnt_q;
    to_cnt_d   = to_cnt_q;
    done_d     = 1'b0;
    err_d      = 1'b0;
    err_code_d = err_code_q;

    case (state_q)
      ST_IDLE: begin
        if (tx_req) begin
          shift_d   = {ps2_parity(tx_data, ODD_PARITY != 0), tx_data};
          inh_cnt_d = INH_LOAD;
          state_d   = ST_INHIBIT;
        end
      end

      ST_INHIBIT: begin
        if (inh_cnt_q == '0) begin
          to_cnt_d = '0;
          state_d  = ST_START;
        end else begin
          inh_cnt_d = inh_cnt_q - IW'(1);
        end
      end

      // Fall 1: the device has seen the start bit; bit 0 goes out.
      ST_START: begin
        if (fall) begin
          bit_cnt_d = '0;
          state_d   = ST_DATA;
        end
      end

      // Falls 2..9: advance one bit per edge. Once bit 7 has been shifted
      // away the parity bit sits in shift_q[0].
      ST_DATA: begin
        if (fall) begin
          shift_d = {1'b0, shift_q[8:1]};
          if (bit_cnt_q == BIT_LAST) begin
            state_d = ST_PARITY;
          end else begin
            bit_cnt_d = bit_cnt_q + BW'(1);
          end
        end
      end

      // Fall 10: stop bit, host lets the line float high.
      ST_PARITY: begin
        if (fall) begin
          state_d = ST_STOP;
        end
      end

      // Fall 11: the device should be holding data low as ACK.
      ST_STOP: begin
        if (fall) begin
          state_d = ST_IDLE;
          if (!data_s2_q) begin
            done_d = 1'b1;
          end else begin
            err_d      = 1'b1;
            err_code_d = ERR_NACK;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Watchdog over each device clock period. A device edge always wins
    // over expiry in the same cycle, so a late-but-valid edge is accepted.
    if (busy) begin
      if (fall) begin
        to_cnt_d = '0;
      end else if (to_cnt_q == TO_LAST) begin
        to_cnt_d   = '0;
        state_d    = ST_IDLE;
        err_d      = 1'b1;
        err_code_d = ERR_TIMEOUT;
      end else begin
        to_cnt_d = to_cnt_q + TW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      bit_cnt_q  <= '0;
      inh_cnt_q  <= '0;
      to_cnt_q   <= '0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      bit_cnt_q  <= bit_cnt_d;
      inh_cnt_q  <= inh_cnt_d;
      to_cnt_q   <= to_cnt_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
    end
  end

  // ------------------------------------------------------------------
  // Open-drain pads
  // ------------------------------------------------------------------
  // Decoded straight from state registers so that reset releases both
  // lines in the same instant it is asserted.
  logic clk_pull;
  logic data_pull;

  assign clk_pull  = (state_q == ST_INHIBIT);
  assign data_pull = ((state_q == ST_INHIBIT) && (inh_cnt_q == '0)) ||
                     (state_q == ST_START) ||
                     (((state_q == ST_DATA) || (state_q == ST_PARITY)) && !shift_q[0]);

  assign ps2_clk  = clk_pull  ? 1'b0 : 1'bz;
  assign ps2_data = data_pull ? 1'b0 : 1'bz;

  assign tx_idle     = (state_q == ST_IDLE);
  assign tx_done     = done_q;
  assign tx_err      = err_q;
  assign tx_err_code = err_code_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
module tb_ps2_host_tx;

  localparam int INH  = 64;
  localparam int FILT = 8;
  localparam int TO   = 600;
  localparam int ODD  = 1;
  localparam int HP   = 40;   // device half clock period in clk cycles

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tx_req = 1'b0;
  logic [7:0] tx_data = 8'h00;
  wire        ps2_clk;
  wire        ps2_data;
  logic       tx_idle;
  logic       tx_done;
  logic       tx_err;
  logic [1:0] tx_err_code;

  logic bfm_clk_low = 1'b0;
  logic bfm_data_low = 1'b0;

  assign ps2_clk  = bfm_clk_low  ? 1'b0 : 1'bz;
  assign ps2_data = bfm_data_low ? 1'b0 : 1'bz;
  pullup (ps2_clk);
  pullup (ps2_data);

  int total = 0;
  int bad = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;

  always #10 clk = ~clk;

  ps2_host_tx #(
    .INHIBIT_CYCLES (INH),
    .FILTER_LEN     (FILT),
    .TIMEOUT_CYCLES (TO),
    .ODD_PARITY     (ODD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .ps2_clk     (ps2_clk),
    .ps2_data    (ps2_data),
    .tx_idle     (tx_idle),
    .tx_done     (tx_done),
    .tx_err      (tx_err),
    .tx_err_code (tx_err_code)
  );

  always @(negedge clk) begin
    if (tx_done) done_cnt <= done_cnt + 1;
    if (tx_err) err_cnt <= err_cnt + 1;
    if (tx_done && tx_err) both_cnt <= both_cnt + 1;
  end

  // Reference frame as the device should see it: {stop, parity, data}.
  function automatic logic [9:0] exp_frame(input logic [7:0] b);
    logic par;
    if (ODD != 0) par = (($countones(b) % 2) == 0) ? 1'b1 : 1'b0;
    else          par = (($countones(b) % 2) == 1) ? 1'b1 : 1'b0;
    return {1'b1, par, b};
  endfunction

  task automatic request(input logic [7:0] b);
    @(negedge clk);
    tx_req  = 1'b1;
    tx_data = b;
    @(negedge clk);
    tx_req  = 1'b0;
  endtask

  // Device model: waits for inhibit and start, then generates 11 clock
  // pulses, sampling data just before each rising edge. Optional glitch,
  // mid-transfer request, or early return (for abort) after a given fall.
  task automatic bfm_xfer(input int ack, input int glitch_at, input int req_at,
                          input logic [7:0] req_byte, input int abort_at,
                          output logic [9:0] rx, output int inh_len,
                          output logic start_bit, output int ok);
    int n;
    ok = 0; rx = '0; inh_len = 0; start_bit = 1'b1; n = 0;
    while (ps2_clk !== 1'b0 && n < 200) begin @(negedge clk); n++; end
    if (ps2_clk !== 1'b0) return;
    while (ps2_clk === 1'b0 && inh_len < 5000) begin @(negedge clk); inh_len++; end
    start_bit = ps2_data;
    repeat (30) @(negedge clk);
    for (int f = 1; f <= 11; f++) begin
      if (f == 11 && ack != 0) begin
        bfm_data_low = 1'b1;
        repeat (5) @(negedge clk);
      end
      bfm_clk_low = 1'b1;
      repeat (HP) @(negedge clk);
      if (f <= 10) rx[f-1] = ps2_data;
      bfm_clk_low = 1'b0;
      if (f == abort_at) begin
        repeat (10) @(negedge clk);
        ok = 1;
        return;
      end
      if (f == glitch_at) begin
        repeat (10) @(negedge clk);
        bfm_clk_low = 1'b1;
        repeat (3) @(negedge clk);
        bfm_clk_low = 1'b0;
        repeat (HP - 13) @(negedge clk);
      end else if (f == req_at) begin
        repeat (10) @(negedge clk);
        tx_req = 1'b1; tx_data = req_byte;
        @(negedge clk);
        tx_req = 1'b0;
        repeat (HP - 11) @(negedge clk);
      end else begin
        repeat (HP) @(negedge clk);
      end
      if (f == 11) bfm_data_low = 1'b0;
    end
    ok = 1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    total++; if (tx_idle !== 1'b1) begin bad++; $display("FAIL reset_idle: got %b want 1", tx_idle); end
    total++; if (tx_done !== 1'b0) begin bad++; $display("FAIL reset_done: got %b want 0", tx_done); end
    total++; if (tx_err !== 1'b0) begin bad++; $display("FAIL reset_err: got %b want 0", tx_err); end
    total++; if (tx_err_code !== 2'b00) begin bad++; $display("FAIL reset_code: got %b want 00", tx_err_code); end
    total++; if ({ps2_clk, ps2_data} !== 2'b11) begin bad++; $display("FAIL reset_lines: got %b want 11", {ps2_clk, ps2_data}); end
  endtask

  task automatic test_f4_ack();
    logic [9:0] rx; int inh; logic sb; int ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    request(8'hF4);
    bfm_xfer(1, 0, 0, 8'h00, 0, rx, inh, sb, ok);
    repeat (2) @(negedge clk);
    $display("xfer f4_ack data=f4 rx=%h inhibit=%0d", rx, inh);
    total++; if (ok !== 1) begin bad++; $display("FAIL f4_bfm: got %0d want 1", ok); end
    total++; if (inh !== INH) begin bad++; $display("FAIL f4_inhibit_len: got %0d want %0d", inh, INH); end
    total++; if (sb !== 1'b0) begin bad++; $display("FAIL f4_start_bit: got %b want 0", sb); end
    total++; if (rx !== exp_frame(8'hF4)) begin bad++; $display("FAIL f4_frame: got %h want %h", rx, exp_frame(8'hF4)); end
    total++; if (rx[8] !== 1'b0) begin bad++; $display("FAIL f4_parity: got %b want 0", rx[8]); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL f4_done_pulses: got %0d want 1", done_cnt - d0); end
    total++; if (err_cnt - e0 !== 0) begin bad++; $display("FAIL f4_err_pulses: got %0d want 0", err_cnt - e0); end
    total++; if (tx_idle !== 1'b1) begin bad++; $display("FAIL f4_idle_after: got %b want 1", tx_idle); end
  endtask

  task automatic test_ff_nack();
    logic [9:0] rx; int inh; logic sb; int ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    request(8'hFF);
    bfm_xfer(0, 0, 0, 8'h00, 0, rx, inh, sb, ok);
    repeat (2) @(negedge clk);
    $display("xfer ff_nack data=ff rx=%h", rx);
    total++; if (rx !== exp_frame(8'hFF)) begin bad++; $display("FAIL ff_frame: got %h want %h", rx, exp_frame(8'hFF)); end
    total++; if (rx[8] !== 1'b1) begin bad++; $display("FAIL ff_parity: got %b want 1", rx[8]); end
    total++; if (err_cnt - e0 !== 1) begin bad++; $display("FAIL ff_err_pulses: got %0d want 1", err_cnt - e0); end
    total++; if (done_cnt - d0 !== 0) begin bad++; $display("FAIL ff_done_pulses: got %0d want 0", done_cnt - d0); end
    total++; if (tx_err_code !== 2'b01) begin bad++; $display("FAIL ff_code: got %b want 01", tx_err_code); end
  endtask

  task automatic test_timeout();
    int n; int k; logic seen; logic [1:0] lines;
    n = 0; k = 0; seen = 1'b0; lines = 2'bxx;
    request(8'h5A);
    while (ps2_clk === 1'b0 && n < 5000) begin @(negedge clk); n++; end
    while (!seen && k < TO + 50) begin
      @(negedge clk); k++;
      if (tx_err === 1'b1) begin seen = 1'b1; lines = {ps2_clk, ps2_data}; end
    end
    $display("xfer timeout data=5a err_after=%0d", k);
    total++; if (seen !== 1'b1) begin bad++; $display("FAIL to_seen: got %b want 1", seen); end
    total++; if (k !== TO) begin bad++; $display("FAIL to_latency: got %0d want %0d", k, TO); end
    total++; if (tx_err_code !== 2'b10) begin bad++; $display("FAIL to_code: got %b want 10", tx_err_code); end
    total++; if (lines !== 2'b11) begin bad++; $display("FAIL to_lines: got %b want 11", lines); end
    total++; if (tx_idle !== 1'b1) begin bad++; $display("FAIL to_idle: got %b want 1", tx_idle); end
    repeat (20) @(negedge clk);
  endtask

  task automatic test_glitch();
    logic [9:0] rx; int inh; logic sb; int ok; int d0;
    d0 = done_cnt;
    request(8'hA5);
    bfm_xfer(1, 4, 0, 8'h00, 0, rx, inh, sb, ok);
    repeat (2) @(negedge clk);
    $display("xfer glitch data=a5 rx=%h", rx);
    total++; if (rx !== exp_frame(8'hA5)) begin bad++; $display("FAIL glitch_frame: got %h want %h", rx, exp_frame(8'hA5)); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL glitch_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_abort_reset();
    logic [9:0] rx; int inh; logic sb; int ok; int d0, e0;
    d0 = done_cnt; e0 = err_cnt;
    request(8'hF4);
    bfm_xfer(1, 0, 0, 8'h00, 2, rx, inh, sb, ok);
    total++; if (ps2_data !== 1'b0) begin bad++; $display("FAIL abort_bit1_driven: got %b want 0", ps2_data); end
    rst_n = 1'b0;
    #1;
    total++; if ({ps2_clk, ps2_data} !== 2'b11) begin bad++; $display("FAIL abort_lines: got %b want 11", {ps2_clk, ps2_data}); end
    total++; if (tx_idle !== 1'b1) begin bad++; $display("FAIL abort_idle: got %b want 1", tx_idle); end
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    total++; if ((done_cnt - d0) + (err_cnt - e0) !== 0) begin bad++; $display("FAIL abort_pulses: got %0d want 0", (done_cnt - d0) + (err_cnt - e0)); end
    d0 = done_cnt;
    request(8'hF4);
    bfm_xfer(1, 0, 0, 8'h00, 0, rx, inh, sb, ok);
    repeat (2) @(negedge clk);
    $display("xfer after_reset data=f4 rx=%h", rx);
    total++; if (rx !== exp_frame(8'hF4)) begin bad++; $display("FAIL abort_next_frame: got %h want %h", rx, exp_frame(8'hF4)); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL abort_next_done: got %0d want 1", done_cnt - d0); end
  endtask

  task automatic test_req_ignored();
    logic [9:0] rx; int inh; logic sb; int ok; int d0; int lows;
    d0 = done_cnt; lows = 0;
    request(8'h3C);
    bfm_xfer(1, 0, 4, 8'hC3, 0, rx, inh, sb, ok);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ps2_clk === 1'b0) lows++;
    end
    $display("xfer req_ignored data=3c rx=%h", rx);
    total++; if (rx !== exp_frame(8'h3C)) begin bad++; $display("FAIL reqign_frame: got %h want %h", rx, exp_frame(8'h3C)); end
    total++; if (done_cnt - d0 !== 1) begin bad++; $display("FAIL reqign_done: got %0d want 1", done_cnt - d0); end
    total++; if (lows !== 0) begin bad++; $display("FAIL reqign_no_restart: got %0d want 0", lows); end
  endtask

  task automatic test_random();
    logic [9:0] rx; int inh; logic sb; int ok; int d0, e0;
    logic [7:0] b; int ack;
    for (int i = 0; i < 4; i++) begin
      b = 8'($urandom); ack = int'($urandom_range(0, 1));
      d0 = done_cnt; e0 = err_cnt;
      request(b);
      bfm_xfer(ack, 0, 0, 8'h00, 0, rx, inh, sb, ok);
      repeat (2) @(negedge clk);
      $display("xfer random data=%h ack=%0d rx=%h", b, ack, rx);
      total++; if (rx !== exp_frame(b)) begin bad++; $display("FAIL rnd_frame: got %h want %h", rx, exp_frame(b)); end
      total++; if (done_cnt - d0 !== ack) begin bad++; $display("FAIL rnd_done: got %0d want %0d", done_cnt - d0, ack); end
      total++; if (err_cnt - e0 !== 1 - ack) begin bad++; $display("FAIL rnd_err: got %0d want %0d", err_cnt - e0, 1 - ack); end
      if (ack == 0) begin
        total++; if (tx_err_code !== 2'b01) begin bad++; $display("FAIL rnd_code: got %b want 01", tx_err_code); end
      end
    end
    total++; if (both_cnt !== 0) begin bad++; $display("FAIL done_err_overlap: got %0d want 0", both_cnt); end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    test_reset();
    test_f4_ack();
    test_ff_nack();
    test_timeout();
    test_glitch();
    test_abort_reset();
    test_req_ignored();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #(20 * 90000);
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
